// File: rtl/apb_reg_bank_if.sv
// APB3 bus bundle between a bridge (master) and the register-bank slave.
// The slave captures the request signals and returns a registered response.
interface apb_reg_bank_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic                pready;
    logic                pslverr;
    logic [DATA_W-1:0]   prdata;

    modport master (
        output paddr, pwdata, pstrb, psel, penable, pwrite,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, pwdata, pstrb, psel, penable, pwrite,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_reg_bank.sv
// Parametrised APB3 register bank: RW/RO word registers, byte strobes,
// programmable wait states, full decode with error response, write pulses.
module apb_reg_bank #(
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         NUM_REGS    = 8,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                         pclk_i,
    input  logic                         presetn_i,
    apb_reg_bank_if.slave                apb_io,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_in_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] OffsMask = ADDR_W'(STRB_W - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              unaligned;
    logic              is_ro;
    logic              acc_err;
    logic              do_write;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] wr_val;

    // Decode always works on the captured request, never the live bus.
    always_comb begin
        idx_full  = addr_q >> OFFS_W;
        idx       = idx_full[IDX_W-1:0];
        in_range  = idx_full < ADDR_W'(NUM_REGS);
        unaligned = |(addr_q & OffsMask);
        is_ro     = in_range && RO_MASK[idx];
        acc_err   = !in_range || unaligned || (write_q && is_ro);
        rd_val    = is_ro ? ro_in_i[idx*DATA_W +: DATA_W] : regs_q[idx];
        wr_val    = regs_q[idx];
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb_q[b]) wr_val[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        wr_pulse_d = '0;
        do_write   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (apb_io.psel && !apb_io.penable) begin
                    addr_d  = apb_io.paddr;
                    write_d = apb_io.pwrite;
                    wdata_d = apb_io.pwdata;
                    strb_d  = apb_io.pstrb;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!apb_io.psel) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = StResp;
                    pready_d  = 1'b1;
                    pslverr_d = acc_err;
                    if (!acc_err) begin
                        if (write_q) begin
                            do_write        = 1'b1;
                            wr_pulse_d[idx] = 1'b1;
                        end else begin
                            prdata_d = rd_val;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            if (do_write) regs_q[idx] <= wr_val;
        end
    end

    assign apb_io.pready  = pready_q;
    assign apb_io.pslverr = pslverr_q;
    assign apb_io.prdata  = prdata_q;
    assign wr_pulse_o     = wr_pulse_q;

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg_out
        assign reg_out_o[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench: two bank instances (0 and 3 wait states) driven through
// a shared APB master and compared against a word-array reference model.
module tb_apb_reg_bank;

    localparam int unsigned     NRegs  = 8;
    localparam logic [7:0]      RoMask = 8'h08;
    localparam logic [31:0]     RstVal = 32'h1234_5678;
    localparam int              Ws0    = 0;
    localparam int              Ws1    = 3;

    logic         pclk = 1'b0;
    logic         presetn = 1'b0;
    logic         sel = 1'b0;
    logic [31:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [255:0] ro0 = '0;
    logic [255:0] ro1 = '0;
    logic [255:0] reg_out0, reg_out1;
    logic [7:0]   pulse0, pulse1;

    logic [31:0]  mdl [2][NRegs];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 pclk = ~pclk;

    apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;
    assign bus0.pwrite  = pwrite;
    assign bus0.penable = penable;
    assign bus0.psel    = psel && !sel;
    assign bus1.paddr   = paddr;
    assign bus1.pwdata  = pwdata;
    assign bus1.pstrb   = pstrb;
    assign bus1.pwrite  = pwrite;
    assign bus1.penable = penable;
    assign bus1.psel    = psel && sel;

    apb_reg_bank #(
        .DATA_W(32), .ADDR_W(32), .NUM_REGS(NRegs), .WAIT_STATES(Ws0),
        .RO_MASK(RoMask), .RESET_VAL(RstVal)
    ) u_dut0 (
        .pclk_i(pclk), .presetn_i(presetn), .apb_io(bus0),
        .reg_out_o(reg_out0), .ro_in_i(ro0), .wr_pulse_o(pulse0)
    );

    apb_reg_bank #(
        .DATA_W(32), .ADDR_W(32), .NUM_REGS(NRegs), .WAIT_STATES(Ws1),
        .RO_MASK(RoMask), .RESET_VAL(RstVal)
    ) u_dut1 (
        .pclk_i(pclk), .presetn_i(presetn), .apb_io(bus1),
        .reg_out_o(reg_out1), .ro_in_i(ro1), .wr_pulse_o(pulse1)
    );

    logic         rdy_s, err_s;
    logic [31:0]  rd_s;
    logic [7:0]   pulse_s;
    logic [255:0] regout_s;
    assign rdy_s    = sel ? bus1.pready  : bus0.pready;
    assign err_s    = sel ? bus1.pslverr : bus0.pslverr;
    assign rd_s     = sel ? bus1.prdata  : bus0.prdata;
    assign pulse_s  = sel ? pulse1 : pulse0;
    assign regout_s = sel ? reg_out1 : reg_out0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(NRegs); i++) mdl[d][i] = RstVal;
    endtask

    // Reference behaviour: word-indexed array, errors decided from the address rules.
    task automatic model_access(input int d, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                output logic err, output logic [31:0] rdata,
                                output logic [7:0] pulse);
        logic [31:0] idx;
        logic        ro;
        logic [255:0] ro_flat;
        idx     = addr / 4;
        ro      = (idx < NRegs) && (((RoMask >> idx) & 8'd1) != 8'd0);
        err     = (addr % 4 != 0) || (idx >= NRegs) || (wr && ro);
        rdata   = '0;
        pulse   = '0;
        ro_flat = (d == 0) ? ro0 : ro1;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
                pulse[idx] = 1'b1;
            end else begin
                rdata = ro ? ro_flat[idx*32 +: 32] : mdl[d][idx];
            end
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(NRegs); i++)
            check_eq(tag, regout_s[i*32 +: 32], mdl[sel][i]);
    endtask

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic apb_xfer(input int d, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_pulse;
        int          lat;
        int          ws;
        ws = (d == 0) ? Ws0 : Ws1;
        model_access(d, addr, wr, wdata, strb, exp_err, exp_rd, exp_pulse);
        sel = (d != 0); paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
        psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr = ~addr; pwdata = ~wdata;
        lat = 0;
        do begin
            @(negedge pclk);
            lat++;
            if (!rdy_s) begin
                check_eq("wait_pslverr", 64'(err_s), 64'd0);
                check_eq("wait_prdata", 64'(rd_s), 64'd0);
                check_eq("wait_wr_pulse", 64'(pulse_s), 64'd0);
            end
        end while (!rdy_s && lat < 40);
        check_eq("latency", 64'(lat), 64'(ws + 2));
        check_eq("pslverr", 64'(err_s), 64'(exp_err));
        if (!wr) check_eq("prdata", 64'(rd_s), 64'(exp_rd));
        check_eq("wr_pulse", 64'(pulse_s), 64'(exp_pulse));
        check_regs("reg_out");
        rdata = rd_s;
        err   = err_s;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Master drops psel after `hold` access-phase edges; no response may appear.
    task automatic apb_abort(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                             input int hold);
        sel = (d != 0); paddr = addr; pwrite = 1'b1; pwdata = wdata; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (hold) begin @(posedge pclk); #1; end
        psel = 1'b0; penable = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            check_eq("abort_pready", 64'(rdy_s), 64'd0);
            check_eq("abort_wr_pulse", 64'(pulse_s), 64'd0);
        end
        check_regs("abort_reg_out");
        @(posedge pclk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          r;
    logic [31:0] a;

    initial begin
        model_reset();
        repeat (3) @(negedge pclk);
        sel = 1'b0; check_eq("rst_pready0", 64'(rdy_s), 64'd0);
        check_regs("rst_reg_out0");
        sel = 1'b1; check_eq("rst_pready1", 64'(rdy_s), 64'd0);
        check_regs("rst_reg_out1");
        presetn = 1'b1;
        @(posedge pclk); #1;

        apb_xfer(0, 32'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er);
        apb_xfer(0, 32'h04, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("rd_deadbeef", 64'(rd), 64'hDEAD_BEEF);
        apb_xfer(0, 32'h00, 1'b1, 32'hAAAA_AAAA, 4'hF, rd, er);
        apb_xfer(0, 32'h00, 1'b1, 32'h1122_3344, 4'b0101, rd, er);
        apb_xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, rd, er);
        check_eq("rd_strobed", 64'(rd), 64'hAA22_AA44);
        apb_xfer(0, 32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er);
        check_eq("zero_strb_err", 64'(er), 64'd0);

        apb_xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("oor_err", 64'(er), 64'd1);
        apb_xfer(0, 32'h06, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("unaligned_err", 64'(er), 64'd1);
        apb_xfer(0, 32'h0C, 1'b1, 32'h5555_5555, 4'hF, rd, er);
        check_eq("ro_write_err", 64'(er), 64'd1);
        apb_xfer(0, 32'h8000_0004, 1'b1, 32'h0BAD_0BAD, 4'hF, rd, er);
        check_eq("high_addr_err", 64'(er), 64'd1);

        ro1[3*32 +: 32] = 32'h0000_5A5A;
        apb_xfer(1, 32'h0C, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("ro_read_ws3", 64'(rd), 64'h5A5A);

        apb_xfer(0, 32'h08, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er);
        apb_abort(0, 32'h08, 32'h0101_0101, 0);
        apb_xfer(0, 32'h08, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("abort_prior0", 64'(rd), 64'hCAFE_F00D);
        apb_xfer(1, 32'h08, 1'b1, 32'h7777_8888, 4'hF, rd, er);
        apb_abort(1, 32'h08, 32'h0202_0202, 2);
        apb_xfer(1, 32'h08, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("abort_prior1", 64'(rd), 64'h7777_8888);

        for (int n = 0; n < 80; n++) begin
            ro0 = {8{$urandom}};
            ro1 = {8{$urandom}};
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 7) * 4);
            else if (r == 7) a = 32'($urandom_range(8, 15) * 4);
            else if (r == 8) a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
            else             a = {$urandom} & 32'hFFFF_FFFC;
            apb_xfer(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
                     4'($urandom_range(0, 15)), rd, er);
        end

        // Reset in the middle of a waited write to reg 2 must leave no trace.
        sel = 1'b1; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h9999_9999; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0;
        model_reset();
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check_eq("midrst_pready", 64'(rdy_s), 64'd0);
        check_eq("midrst_wr_pulse", 64'(pulse_s), 64'd0);
        check_regs("midrst_reg_out1");
        sel = 1'b0;
        check_regs("midrst_reg_out0");
        @(posedge pclk); #1;
        apb_xfer(1, 32'h08, 1'b0, 32'h0, 4'hF, rd, er);
        check_eq("midrst_readback", 64'(rd), 64'(RstVal));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB3 register-bank slave: next generation of the team's single-register APB slave. Provides NUM_REGS word-wide registers, each either read/write (software-owned) or read-only (hardware status). Adds byte strobes, programmable wait states, full address decode with error response, and per-register write strobes to downstream logic. Sits on the peripheral APB bus behind the bridge; one instance per peripheral control block.

## Interface
Parameters:
- DATA_W, 32, register/bus data width; legal values 8, 16, 32, 64
- ADDR_W, 32, paddr width
- NUM_REGS, 8, number of registers, 1..256
- WAIT_STATES, 0, extra pready-low cycles inserted per access, 0..15
- RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only (value from ro_in)
- RESET_VAL, 0, DATA_W-bit reset value of every RW register

Ports (one clock `pclk`; reset `presetn` is asynchronous, active-low):
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  write byte enables
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid only with pready
- prdata  out  DATA_W  read data, valid only with pready on reads
- reg_out  out  NUM_REGS*DATA_W  flat RW register contents, register i at [i*DATA_W +: DATA_W]
- ro_in  in  NUM_REGS*DATA_W  flat hardware status values for RO registers
- wr_pulse  out  NUM_REGS  one-cycle pulse per register written

## Operation
- Word index = paddr >> log2(DATA_W/8). Full decode: all paddr bits above the index range participate; index >= NUM_REGS is out of range.
- Error (pslverr=1, no state change) when: index out of range; paddr low byte-offset bits nonzero (unaligned); write to RO register. Reads of error addresses return prdata=0.
- Writes: byte lane b of register updated only where pstrb[b]=1; pstrb all-zero is a legal no-op write (no error, wr_pulse still asserted).
- Reads: RW register returns stored value; RO register returns ro_in slice sampled at the completing edge.
- FSM states:
  - IDLE: psel && !penable → ACCESS, wait counter loaded with WAIT_STATES, paddr/pwrite/pwdata/pstrb captured. psel && penable in IDLE is ignored.
  - ACCESS: if !psel → IDLE (abort, no write, no response). Else counter > 0 → decrement. Counter == 0 → perform decode/write, register pready=1 plus pslverr/prdata, → RESP.
  - RESP: pready=1 for exactly one cycle; next edge → IDLE, pready/pslverr/prdata cleared to 0.
- Captured address/data used for decode; master changes in access phase are ignored.
- wr_pulse[i] asserted in the RESP cycle of a successful write to register i, same cycle reg_out shows the new value.

## Timing
- Reset (asynchronous assert, deasserts synchronously to pclk externally): pready=0, pslverr=0, prdata=0, wr_pulse=0, all RW registers = RESET_VAL, FSM = IDLE, counter = 0. Reset mid-transfer aborts it; no partial write.
- Setup sampled at edge E0; pready high in cycle after edge E1+WAIT_STATES; total access phase = WAIT_STATES+2 cycles (one inherent registered wait).
- Back-to-back: new setup may occur in the cycle after RESP and is accepted.
- pslverr and prdata are 0 whenever pready=0.
- All outputs registered; no combinational path input→output.

## Test plan
- Reset: hold presetn=0 mid-write to reg 2 → pready=0, reg_out all RESET_VAL, wr_pulse=0 after release.
- Write 0xDEADBEEF to 0x04 (WAIT_STATES=0, pstrb=4'hF) then read 0x04 → pready high in 2nd access cycle, prdata=0xDEADBEEF, pslverr=0, wr_pulse[1] one cycle.
- Strobed write 0x11223344 to 0x00 with pstrb=4'b0101 over 0xAAAAAAAA → reads back 0xAA22AA44.
- Errors: read 0x20 with NUM_REGS=8, read 0x06, write RO reg 3 (RO_MASK=8'h08) → pslverr=1, prdata=0, register contents and wr_pulse unchanged.
- WAIT_STATES=3: read RO reg 3 with ro_in slice=0x0000_5A5A → pready low 4 access cycles, high on 5th with prdata=0x5A5A.
- Abort: drop psel during ACCESS of write to 0x08 → no write, no pready; following read of 0x08 returns prior value.
